// File: rtl/regfile_2w_scrub.sv
// regfile_2w_scrub: register file with two read ports and two write ports. It
// bypasses same-cycle writes to the read ports and keeps a pending (scoreboard)
// bit per register. Reset starts a scrub that clears one register per cycle.
// READY goes high when the scrub is complete.
//
// Ports:
//   CLK               clock, all state updates on posedge
//   RST_N             synchronous active-low reset, starts a scrub
//   ADR1, ADR2        read addresses
//   RS1, RS2          read data (combinational, with write bypass)
//   BUSY1, BUSY2      pending status of ADR1/ADR2 (combinational)
//   WE0/WA0/WD0       write lane 0
//   WE1/WA1/WD1       write lane 1 (wins over lane 0 on address collision)
//   RSV_EN, RSV_ADR   reserve request, marks RSV_ADR pending
//   READY             scrub done, block accepts traffic
module regfile_2w_scrub #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NREGS   = 32,
    parameter int unsigned ZERO_R0 = 1,
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [AW-1:0]   ADR1,
    input  logic [AW-1:0]   ADR2,
    output logic [XLEN-1:0] RS1,
    output logic [XLEN-1:0] RS2,
    output logic            BUSY1,
    output logic            BUSY2,
    input  logic            WE0,
    input  logic            WE1,
    input  logic [AW-1:0]   WA0,
    input  logic [AW-1:0]   WA1,
    input  logic [XLEN-1:0] WD0,
    input  logic [XLEN-1:0] WD1,
    input  logic            RSV_EN,
    input  logic [AW-1:0]   RSV_ADR,
    output logic            READY
);

    localparam bit          zero_r0  = (ZERO_R0 != 0);
    localparam logic [AW:0] last_idx = (AW + 1)'(NREGS - 1);

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e           state_q, state_d;
    logic [AW:0]      idx_q, idx_d;
    logic [NREGS-1:0] pend_q, pend_d;
    logic [XLEN-1:0]  mem_q [NREGS];

    logic run;
    logic scrub_we;
    logic we0_ok, we1_ok, rsv_ok;

    assign run = (state_q == StRun);
    // The MSB guard stops a stray scrub write once idx has run past the last register.
    assign scrub_we = (state_q == StClear) && !idx_q[AW];

    // Writes and reserves to r0 are dropped when r0 is hardwired to zero.
    assign we0_ok = run && WE0 && ((WA0 != '0) || !zero_r0);
    assign we1_ok = run && WE1 && ((WA1 != '0) || !zero_r0);
    assign rsv_ok = run && RSV_EN && ((RSV_ADR != '0) || !zero_r0);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StClear: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == last_idx) begin
                    state_d = StRun;
                end
            end
            StRun: begin
            end
        endcase
    end

    always_comb begin
        pend_d = pend_q;
        if (we0_ok) pend_d[WA0] = 1'b0;
        if (we1_ok) pend_d[WA1] = 1'b0;
        // Reserve is applied last so it wins over a same-cycle write.
        if (rsv_ok) pend_d[RSV_ADR] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= StClear;
            idx_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
        end
    end

    // Storage has no reset; the scrub defines its contents. Lane 1 is written
    // last so it wins on a collision.
    always_ff @(posedge CLK) begin
        if (RST_N) begin
            if (scrub_we) mem_q[idx_q[AW-1:0]] <= '0;
            if (we0_ok)   mem_q[WA0] <= WD0;
            if (we1_ok)   mem_q[WA1] <= WD1;
        end
    end

    always_comb begin
        RS1 = '0;
        if (run && !(zero_r0 && (ADR1 == '0))) begin
            if (we1_ok && (WA1 == ADR1))      RS1 = WD1;
            else if (we0_ok && (WA0 == ADR1)) RS1 = WD0;
            else                              RS1 = mem_q[ADR1];
        end
    end

    always_comb begin
        RS2 = '0;
        if (run && !(zero_r0 && (ADR2 == '0))) begin
            if (we1_ok && (WA1 == ADR2))      RS2 = WD1;
            else if (we0_ok && (WA0 == ADR2)) RS2 = WD0;
            else                              RS2 = mem_q[ADR2];
        end
    end

    // A write landing this cycle hides the pending bit it is about to clear.
    assign BUSY1 = run && pend_q[ADR1]
                   && !(we0_ok && (WA0 == ADR1)) && !(we1_ok && (WA1 == ADR1));
    assign BUSY2 = run && pend_q[ADR2]
                   && !(we0_ok && (WA0 == ADR2)) && !(we1_ok && (WA1 == ADR2));

    assign READY = run;

endmodule

// File: tb/tb_regfile_2w_scrub.sv
module tb_regfile_2w_scrub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  adr1, adr2, wa0, wa1, rsv_adr;
    logic [31:0] rs1, rs2, wd0, wd1;
    logic        busy1, busy2, we0, we1, rsv_en, ready;

    logic        s_rst_n;
    logic [2:0]  s_adr1, s_adr2, s_wa0, s_wa1, s_rsv_adr;
    logic [15:0] s_rs1, s_rs2, s_wd0, s_wd1;
    logic        s_busy1, s_busy2, s_we0, s_we1, s_rsv_en, s_ready;

    // Reference model for the 32x32 instance.
    logic [31:0] mem_m [32];
    logic [31:0] pend_m;
    bit          run_m;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_2w_scrub dut (
        .CLK(clk), .RST_N(rst_n), .ADR1(adr1), .ADR2(adr2), .RS1(rs1), .RS2(rs2),
        .BUSY1(busy1), .BUSY2(busy2), .WE0(we0), .WE1(we1), .WA0(wa0), .WA1(wa1),
        .WD0(wd0), .WD1(wd1), .RSV_EN(rsv_en), .RSV_ADR(rsv_adr), .READY(ready)
    );

    regfile_2w_scrub #(.XLEN(16), .NREGS(8), .ZERO_R0(1)) dut_s (
        .CLK(clk), .RST_N(s_rst_n), .ADR1(s_adr1), .ADR2(s_adr2), .RS1(s_rs1),
        .RS2(s_rs2), .BUSY1(s_busy1), .BUSY2(s_busy2), .WE0(s_we0), .WE1(s_we1),
        .WA0(s_wa0), .WA1(s_wa1), .WD0(s_wd0), .WD1(s_wd1), .RSV_EN(s_rsv_en),
        .RSV_ADR(s_rsv_adr), .READY(s_ready)
    );

    function automatic logic [31:0] exp_rs(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (we1 && wa1 == a) return wd1;
        if (we0 && wa0 == a) return wd0;
        return mem_m[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 0) return 1'b0;
        if ((we0 && wa0 == a) || (we1 && wa1 == a)) return 1'b0;
        return pend_m[a];
    endfunction

    task automatic idle();
        we0 = 0; we1 = 0; rsv_en = 0;
    endtask

    // Advance one clock, folding the presented inputs into the model first.
    task automatic tick();
        if (!rst_n) begin
            pend_m = '0;
            run_m  = 0;
        end else if (run_m) begin
            if (we0 && wa0 != 0) begin mem_m[wa0] = wd0; pend_m[wa0] = 1'b0; end
            if (we1 && wa1 != 0) begin mem_m[wa1] = wd1; pend_m[wa1] = 1'b0; end
            if (rsv_en && rsv_adr != 0) pend_m[rsv_adr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic scrubbed_model();
        for (int i = 0; i < 32; i++) mem_m[i] = '0;
        pend_m = '0;
        run_m  = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        we0 = 1; wa0 = 5'd5; wd0 = 32'hFFFF_FFFF; adr1 = 5'd5; adr2 = 5'd9;
        repeat (3) tick();
        checks++;
        if (ready !== 1'b0) begin
            failures++; $display("FAIL reset_ready got=%b exp=0", ready);
        end
        rst_n = 1;
        rsv_en = 1; rsv_adr = 5'd9;
        for (int i = 1; i <= 32; i++) begin
            wa0 = 5'($urandom_range(1, 31)); adr1 = wa0;
            tick();
            checks++;
            if (ready !== (i == 32)) begin
                failures++; $display("FAIL scrub_ready cyc=%0d got=%b exp=%b", i, ready, i == 32);
            end
            if (i < 32) begin
                checks++;
                if (rs1 !== 32'h0 || busy2 !== 1'b0) begin
                    failures++; $display("FAIL clear_outputs cyc=%0d rs1=%h busy2=%b exp=0/0", i, rs1, busy2);
                end
            end
            if (i == 32) idle();
        end
        idle();
        scrubbed_model();
        for (int a = 0; a < 32; a++) begin
            adr1 = 5'(a); adr2 = 5'(31 - a);
            #1;
            checks++;
            if (rs1 !== 32'h0 || rs2 !== 32'h0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
                failures++;
                $display("FAIL post_scrub a=%0d rs1=%h rs2=%h b1=%b b2=%b exp=0", a, rs1, rs2, busy1, busy2);
            end
        end
    endtask

    task automatic test_bypass();
        idle();
        we0 = 1; wa0 = 5'd5; wd0 = 32'hDEAD_BEEF; adr1 = 5'd5;
        #1;
        checks++;
        if (rs1 !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL bypass got=%h exp=deadbeef", rs1);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rs1 !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL bypass_stored got=%h exp=deadbeef", rs1);
        end
    endtask

    task automatic test_dual_write();
        we0 = 1; wa0 = 5'd7; wd0 = 32'h11;
        we1 = 1; wa1 = 5'd7; wd1 = 32'h22; adr1 = 5'd7;
        #1;
        checks++;
        if (rs1 !== 32'h22) begin
            failures++; $display("FAIL dual_bypass got=%h exp=22", rs1);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rs1 !== 32'h22) begin
            failures++; $display("FAIL dual_stored got=%h exp=22", rs1);
        end
        adr2 = 5'd0; we0 = 1; wa0 = 5'd0; wd0 = 32'h33;
        #1;
        checks++;
        if (rs2 !== 32'h0) begin
            failures++; $display("FAIL r0_bypass got=%h exp=0", rs2);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rs2 !== 32'h0) begin
            failures++; $display("FAIL r0_stored got=%h exp=0", rs2);
        end
    endtask

    task automatic test_reserve();
        idle();
        adr1 = 5'd9; rsv_en = 1; rsv_adr = 5'd9;
        tick();
        idle();
        #1;
        checks++;
        if (busy1 !== 1'b1) begin
            failures++; $display("FAIL rsv_set got=%b exp=1", busy1);
        end
        we0 = 1; wa0 = 5'd9; wd0 = 32'h99;
        #1;
        checks++;
        if (busy1 !== 1'b0) begin
            failures++; $display("FAIL rsv_write_hide got=%b exp=0", busy1);
        end
        tick();
        idle();
        #1;
        checks++;
        if (busy1 !== 1'b0) begin
            failures++; $display("FAIL rsv_cleared got=%b exp=0", busy1);
        end
        rsv_en = 1; rsv_adr = 5'd9; we1 = 1; wa1 = 5'd9; wd1 = 32'h77;
        tick();
        idle();
        #1;
        checks++;
        if (busy1 !== 1'b1 || rs1 !== 32'h77) begin
            failures++; $display("FAIL rsv_wins busy=%b rs1=%h exp=1/77", busy1, rs1);
        end
    endtask

    task automatic test_random();
        logic [31:0] e1, e2;
        logic        b1, b2;
        for (int n = 0; n < 400; n++) begin
            we0 = 1'($urandom); we1 = 1'($urandom); rsv_en = ($urandom_range(0, 3) == 0);
            wa0 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            wa1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            rsv_adr = 5'($urandom_range(0, 7));
            adr1 = 5'($urandom_range(0, 7));
            adr2 = ($urandom_range(0, 1) == 0) ? wa1 : 5'($urandom);
            wd0 = $urandom; wd1 = $urandom;
            #1;
            e1 = exp_rs(adr1); e2 = exp_rs(adr2);
            b1 = exp_busy(adr1); b2 = exp_busy(adr2);
            checks++;
            if (rs1 !== e1 || busy1 !== b1) begin
                failures++;
                $display("FAIL rand_p1 n=%0d a=%0d rs=%h busy=%b exp=%h/%b", n, adr1, rs1, busy1, e1, b1);
            end
            checks++;
            if (rs2 !== e2 || busy2 !== b2) begin
                failures++;
                $display("FAIL rand_p2 n=%0d a=%0d rs=%h busy=%b exp=%h/%b", n, adr2, rs2, busy2, e2, b2);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_mid_reset();
        int n;
        idle();
        we0 = 1; wa0 = 5'd3; wd0 = 32'hAA; rsv_en = 1; rsv_adr = 5'd4;
        tick();
        idle();
        adr1 = 5'd4; adr2 = 5'd3;
        #1;
        checks++;
        if (busy1 !== 1'b1 || rs2 !== 32'hAA) begin
            failures++; $display("FAIL mid_setup busy=%b rs2=%h exp=1/aa", busy1, rs2);
        end
        rst_n = 0; we0 = 1; wa0 = 5'd3; wd0 = 32'h55;
        tick();
        checks++;
        if (ready !== 1'b0 || busy1 !== 1'b0 || rs2 !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset ready=%b busy=%b rs2=%h exp=0/0/0", ready, busy1, rs2);
        end
        rst_n = 1;
        idle();
        n = 0;
        while (!ready && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n != 32 || ready !== 1'b1) begin
            failures++; $display("FAIL mid_rescrub cycles=%0d ready=%b exp=32/1", n, ready);
        end
        scrubbed_model();
        #1;
        checks++;
        if (rs2 !== 32'h0 || busy1 !== 1'b0) begin
            failures++; $display("FAIL mid_after rs2=%h busy=%b exp=0/0", rs2, busy1);
        end
    endtask

    task automatic test_small();
        int n;
        s_we0 = 0; s_we1 = 0; s_rsv_en = 0; s_adr1 = 3'd7; s_adr2 = 3'd0;
        s_rst_n = 1;
        n = 0;
        while (!s_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != 8 || s_ready !== 1'b1) begin
            failures++; $display("FAIL small_scrub cycles=%0d ready=%b exp=8/1", n, s_ready);
        end
        s_we0 = 1; s_wa0 = 3'd7; s_wd0 = 16'hFFFF;
        s_we1 = 1; s_wa1 = 3'd0; s_wd1 = 16'h1234;
        #1;
        checks++;
        if (s_rs1 !== 16'hFFFF || s_rs2 !== 16'h0) begin
            failures++; $display("FAIL small_bypass rs1=%h rs2=%h exp=ffff/0", s_rs1, s_rs2);
        end
        tick();
        s_we0 = 0; s_we1 = 0;
        #1;
        checks++;
        if (s_rs1 !== 16'hFFFF || s_rs2 !== 16'h0) begin
            failures++; $display("FAIL small_stored rs1=%h rs2=%h exp=ffff/0", s_rs1, s_rs2);
        end
    endtask

    initial begin
        rst_n = 0; s_rst_n = 0;
        adr1 = 0; adr2 = 0; wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; rsv_adr = 0;
        we0 = 0; we1 = 0; rsv_en = 0; run_m = 0; pend_m = '0;
        s_adr1 = 0; s_adr2 = 0; s_wa0 = 0; s_wa1 = 0; s_wd0 = 0; s_wd1 = 0;
        s_rsv_adr = 0; s_we0 = 0; s_we1 = 0; s_rsv_en = 0;
        @(negedge clk);
        test_reset();
        test_bypass();
        test_dual_write();
        test_reserve();
        test_random();
        test_mid_reset();
        test_small();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
